// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth multiply-accumulate slice: state encoding, saturation
// limits and batch-counter sizing.
package booth_mac_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned length);
      return (length > 1) ? $clog2(length) : 1;
   endfunction

   function automatic longint sat_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/booth_sat_adder.sv
// Signed W-bit adder with two's-complement overflow detection.
// Define ACC_SATURATE_EN to clamp overflowing sums to the signed limits instead of wrapping.
module booth_sat_adder
   import booth_mac_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   logic signed [W-1:0] raw;

   assign raw = a + b;
   // Overflow only when both operands agree in sign and the result does not.
   assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ACC_SATURATE_EN
   localparam logic signed [W-1:0] SatMax = W'(sat_max(W));
   localparam logic signed [W-1:0] SatMin = W'(sat_min(W));

   always_comb begin
      sum = raw;
      if (ovf) begin
         sum = a[W-1] ? SatMin : SatMax;
      end
   end
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates LENGTH signed products per batch and emits the sum with a one-cycle valid pulse.
// Optional ACC_SATURATE_EN (in booth_sat_adder) selects saturating instead of wrapping sums.
module booth_product_accumulator
   import booth_mac_pkg::*;
#(
   parameter  int unsigned NUMBER_OF_BITS = 4,
   parameter  int unsigned ACC_BITS       = 16,
   parameter  int unsigned LENGTH         = 4,
   localparam int unsigned CNT_W          = cnt_width(LENGTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [2*NUMBER_OF_BITS-1:0]   product_in,
   input  logic                          product_valid,
   input  logic                          clear,
   output logic signed [ACC_BITS-1:0]    acc_out,
   output logic                          acc_valid,
   output logic                          overflow,
   output logic [CNT_W-1:0]              count,
   output logic                          busy
);

   state_e                      state_q, state_d;
   logic signed [ACC_BITS-1:0]  acc_q, acc_d;
   logic signed [ACC_BITS-1:0]  acc_out_q, acc_out_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        ovf_r_q, ovf_r_d;
   logic                        acc_valid_q, acc_valid_d;
   logic                        overflow_q, overflow_d;

   logic signed [ACC_BITS-1:0]  prod_ext;
   logic signed [ACC_BITS-1:0]  sum;
   logic                        ovf;
   logic                        last;

   assign prod_ext = ACC_BITS'(signed'(product_in));

   booth_sat_adder #(
      .W (ACC_BITS)
   ) u_add (
      .a   (acc_q),
      .b   (prod_ext),
      .sum (sum),
      .ovf (ovf)
   );

   // In IDLE the counter is zero, so LENGTH==1 dumps straight from IDLE.
   assign last = (cnt_q == CNT_W'(LENGTH - 1));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_r_d     = ovf_r_q;
      acc_out_d   = acc_out_q;
      overflow_d  = overflow_q;
      acc_valid_d = 1'b0;

      if (clear) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_r_d = 1'b0;
      end else if (product_valid) begin
         if (last) begin
            acc_out_d   = sum;
            overflow_d  = ovf_r_q | ovf;
            acc_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_r_d     = 1'b0;
            state_d     = ST_IDLE;
         end else begin
            acc_d   = sum;
            cnt_d   = cnt_q + CNT_W'(1);
            ovf_r_d = ovf_r_q | ovf;
            state_d = ST_ACCUM;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_r_q     <= 1'b0;
         acc_out_q   <= '0;
         overflow_q  <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_r_q     <= ovf_r_d;
         acc_out_q   <= acc_out_d;
         overflow_q  <= overflow_d;
         acc_valid_q <= acc_valid_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign acc_valid = acc_valid_q;
   assign overflow  = overflow_q;
   assign count     = cnt_q;
   assign busy      = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench: three accumulator configurations share one stimulus stream and are each
// checked against an integer-arithmetic batch model.
module tb_booth_product_accumulator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  product_in = '0;
   logic        product_valid = 1'b0;
   logic        clear = 1'b0;

   logic signed [15:0] acc_out0;
   logic signed [7:0]  acc_out1, acc_out2;
   logic               acc_valid0, acc_valid1, acc_valid2;
   logic               overflow0, overflow1, overflow2;
   logic [1:0]         count0, count1;
   logic [0:0]         count2;
   logic               busy0, busy1, busy2;

   always #5 clk = ~clk;

   booth_product_accumulator #(.NUMBER_OF_BITS(4), .ACC_BITS(16), .LENGTH(4)) u_dut0 (
      .clk(clk), .reset(reset), .product_in(product_in), .product_valid(product_valid),
      .clear(clear), .acc_out(acc_out0), .acc_valid(acc_valid0), .overflow(overflow0),
      .count(count0), .busy(busy0));

   booth_product_accumulator #(.NUMBER_OF_BITS(4), .ACC_BITS(8), .LENGTH(3)) u_dut1 (
      .clk(clk), .reset(reset), .product_in(product_in), .product_valid(product_valid),
      .clear(clear), .acc_out(acc_out1), .acc_valid(acc_valid1), .overflow(overflow1),
      .count(count1), .busy(busy1));

   booth_product_accumulator #(.NUMBER_OF_BITS(4), .ACC_BITS(8), .LENGTH(1)) u_dut2 (
      .clk(clk), .reset(reset), .product_in(product_in), .product_valid(product_valid),
      .clear(clear), .acc_out(acc_out2), .acc_valid(acc_valid2), .overflow(overflow2),
      .count(count2), .busy(busy2));

   typedef struct {
      longint v;
      bit     o;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int failures = 0;

   int     mw[3] = '{16, 8, 8};
   int     ml[3] = '{4, 3, 1};
   longint m_acc[3] = '{0, 0, 0};
   int     m_cnt[3] = '{0, 0, 0};
   bit     m_ovf[3] = '{0, 0, 0};
   longint m_out[3] = '{0, 0, 0};
   bit     m_oflag[3] = '{0, 0, 0};
   bit     m_vld[3] = '{0, 0, 0};

`ifdef ACC_SATURATE_EN
   bit sat_mode = 1'b1;
`else
   bit sat_mode = 1'b0;
`endif

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int i, input longint v, input bit o);
      exp_t e;
      e.v = v;
      e.o = o;
      case (i)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Batch model: running sum in plain integers, range-checked against the accumulator width.
   task automatic model_update(input int i, input bit v, input longint p, input bit c,
                               input bit r);
      longint s, hi, lo;
      bit o;
      hi = (longint'(1) <<< (mw[i] - 1)) - 1;
      lo = -(longint'(1) <<< (mw[i] - 1));
      m_vld[i] = 1'b0;
      if (r) begin
         m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_out[i] = 0; m_oflag[i] = 0;
      end else if (c) begin
         m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      end else if (v) begin
         s = m_acc[i] + p;
         o = (s > hi) || (s < lo);
         if (o && sat_mode) s = (s > hi) ? hi : lo;
         else if (s > hi) s = s - (longint'(1) <<< mw[i]);
         else if (s < lo) s = s + (longint'(1) <<< mw[i]);
         m_ovf[i] = m_ovf[i] | o;
         m_cnt[i] = m_cnt[i] + 1;
         if (m_cnt[i] == ml[i]) begin
            push_exp(i, s, m_ovf[i]);
            m_out[i] = s; m_oflag[i] = m_ovf[i]; m_vld[i] = 1'b1;
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
         end else begin
            m_acc[i] = s;
         end
      end
   endtask

   task automatic cmp_dut(input int i, input longint cnt, input bit bsy, input bit vld,
                          input longint out, input bit ovf);
      chk($sformatf("d%0d_count", i), cnt, m_cnt[i]);
      chk($sformatf("d%0d_busy", i), bsy, m_cnt[i] != 0);
      chk($sformatf("d%0d_acc_valid", i), vld, m_vld[i]);
      chk($sformatf("d%0d_acc_out_hold", i), out, m_out[i]);
      chk($sformatf("d%0d_overflow_hold", i), ovf, m_oflag[i]);
   endtask

   task automatic step(input bit v, input int p, input bit c, input bit r);
      @(negedge clk);
      reset = r;
      clear = c;
      product_valid = v;
      product_in = 8'(p);
      for (int i = 0; i < 3; i++) model_update(i, v, longint'(p), c, r);
      @(posedge clk);
      #1;
      cmp_dut(0, longint'(count0), busy0, acc_valid0, longint'(acc_out0), overflow0);
      cmp_dut(1, longint'(count1), busy1, acc_valid1, longint'(acc_out1), overflow1);
      cmp_dut(2, longint'(count2), busy2, acc_valid2, longint'(acc_out2), overflow2);
   endtask

   task automatic pop_cmp(input int i, input longint act, input bit aovf);
      exp_t e;
      bit got;
      got = 1'b0;
      case (i)
         0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      endcase
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL mon%0d_unexpected_pulse actual=%0d required=no_pulse", i, act);
      end else if (act != e.v || aovf != e.o) begin
         failures++;
         $display("FAIL mon%0d_dump actual=%0d/%0d required=%0d/%0d", i, act, aovf, e.v, e.o);
      end
   endtask

   // Monitor: outputs are registered, so mid-cycle sampling sees the pulse cleanly.
   always @(negedge clk) begin
      if (acc_valid0) pop_cmp(0, longint'(acc_out0), overflow0);
      if (acc_valid1) pop_cmp(1, longint'(acc_out1), overflow1);
      if (acc_valid2) pop_cmp(2, longint'(acc_out2), overflow2);
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      int t1[4] = '{6, -8, 15, 49};
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      chk("reset_acc_out", longint'(acc_out0), 0);
      chk("reset_busy", busy0, 0);

      // Products spaced six cycles apart.
      step(1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, t1[k], 1'b0, 1'b0);
         if (k < 3) idle(5);
      end
      chk("t1_acc_out", longint'(acc_out0), 62);
      chk("t1_overflow", overflow0, 0);
      chk("t1_count", longint'(count0), 0);
      chk("t1_busy", busy0, 0);

      // Back-to-back batch then an immediate new product.
      step(1'b0, 0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b1, -64, 1'b0, 1'b0);
      chk("t2_acc_out", longint'(acc_out0), -256);
      chk("t2_valid", acc_valid0, 1);
      step(1'b1, 7, 1'b0, 1'b0);
      chk("t2_new_count", longint'(count0), 1);
      chk("t2_new_busy", busy0, 1);

      // Overflow on the narrow accumulator, then a clean batch clears the flag.
      step(1'b0, 0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 49, 1'b0, 1'b0);
      chk("t3_acc_out", longint'(acc_out1), sat_mode ? 127 : -109);
      chk("t3_overflow", overflow1, 1);
      for (int k = 0; k < 3; k++) step(1'b1, 1, 1'b0, 1'b0);
      chk("t3b_acc_out", longint'(acc_out1), 3);
      chk("t3b_overflow", overflow1, 0);
      chk("t3_d0_acc_out", longint'(acc_out0), 148);

      // Clear discards the partial batch and the coincident product.
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 10, 1'b0, 1'b0);
      step(1'b1, 20, 1'b0, 1'b0);
      step(1'b1, 99, 1'b1, 1'b0);
      chk("t4_hold_after_clear", longint'(acc_out0), 148);
      chk("t4_count_after_clear", longint'(count0), 0);
      for (int k = 1; k <= 4; k++) step(1'b1, k, 1'b0, 1'b0);
      chk("t4_acc_out", longint'(acc_out0), 10);

      // Reset mid-batch.
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b1, 5, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b1, 5, 1'b0, 1'b1);
      chk("t5_reset_acc_out", longint'(acc_out0), 0);
      chk("t5_reset_count", longint'(count0), 0);
      for (int k = 0; k < 4; k++) step(1'b1, 5, 1'b0, 1'b0);
      chk("t5_acc_out", longint'(acc_out0), 20);

      // Single-product batches.
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      chk("t6_first", longint'(acc_out2), 3);
      chk("t6_first_valid", acc_valid2, 1);
      step(1'b1, -2, 1'b0, 1'b0);
      chk("t6_second", longint'(acc_out2), -2);
      chk("t6_second_valid", acc_valid2, 1);
      chk("t6_busy", busy2, 0);

      for (int k = 0; k < 400; k++) begin
         bit v, c, r;
         int p;
         v = ($urandom_range(2) == 0);
         c = ($urandom_range(39) == 0);
         r = ($urandom_range(199) == 0);
         p = int'($urandom_range(255)) - 128;
         step(v, p, c, r);
      end

      idle(3);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
